// File: rtl/fifo_reader.sv
// Pulls words from a synchronous FIFO into a 3-entry in-order buffer and streams them out valid/ready.
// 2-cycle read-to-valid latency; reads throttle on buffer headroom (occ + inflight), never on m_ready.
module fifo_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rempty,
  output logic             rinc,
  input  logic [WIDTH-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic [CNT_W-1:0] rd_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             inflight;
  logic [1:0]       occ;
  logic [WIDTH-1:0] mem0, mem1, mem2;
  logic             pop;
  logic [1:0]       wr_idx;
  logic [2:0]       pending;

  assign pending = {1'b0, occ} + {2'b00, inflight};
  assign pop     = m_valid & m_ready;
  // A word captured on a popping edge lands one slot lower because the buffer shifts.
  assign wr_idx  = occ - {1'b0, pop};

  assign rinc    = (state == RUN) & ~rempty & (pending < 3'd3);
  assign m_valid = (occ != 2'd0);
  assign m_data  = mem0;
  assign busy    = (state != IDLE) | inflight | (occ != 2'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                               state_nxt = RUN;
        else if (!inflight && occ == 2'd0)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      rd_cnt   <= '0;
      mem0     <= '0;
      mem1     <= '0;
      mem2     <= '0;
    end else begin
      inflight <= rinc;
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      if (rinc) rd_cnt <= rd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

      // Head lives in mem0 so m_data comes straight from a register.
      if (inflight && wr_idx == 2'd0) mem0 <= rdata;
      else if (pop)                   mem0 <= mem1;
      if (inflight && wr_idx == 2'd1) mem1 <= rdata;
      else if (pop)                   mem1 <= mem2;
      if (inflight && wr_idx == 2'd2) mem2 <= rdata;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a FIFO model feeds rdata, expected words queue on each accepted read.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rempty = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] rdata = 8'h00;

  logic       rinc, m_valid, busy;
  logic [7:0] m_data;
  logic [15:0] rd_cnt;
  logic       rinc4, m_valid4, busy4;
  logic [7:0] m_data4;
  logic [3:0] rd_cnt4;

  always #5 clk = ~clk;

  fifo_reader dut (
    .clk(clk), .rst(rst), .en(en), .rempty(rempty), .rinc(rinc), .rdata(rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .rd_cnt(rd_cnt)
  );

  fifo_reader #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .rempty(rempty), .rinc(rinc4), .rdata(rdata),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .busy(busy4), .rd_cnt(rd_cnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int   cyc, n_acc, n_vld, first_acc, first_vld, last_vld;
  logic last_acc;
  logic stall_prev;
  logic [7:0] data_prev;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; n_acc = 0; n_vld = 0;
    first_acc = -1; first_vld = -1; last_vld = -1;
    last_acc = 1'b0; stall_prev = 1'b0; data_prev = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    fifo_q.delete(); exp_q.delete();
    rempty = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic load(input int n, input int seed);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'((i * 7 + seed) & 8'hFF));
    rempty = (fifo_q.size() == 0);
  endtask

  // One clock: sample at negedge, then model the FIFO just after the rising edge.
  task automatic step();
    logic acc;
    @(negedge clk);
    cyc++;
    acc = rinc && !rempty;
    if (stall_prev) chk("hold_m_data", m_data, data_prev);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("spurious_valid", m_valid, 0);
      else                   chk("m_data", m_data, exp_q.pop_front());
      n_vld++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
    end
    stall_prev = m_valid && !m_ready;
    data_prev  = m_data;
    if (acc) begin
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    last_acc = acc;
    @(posedge clk); #1;
    if (acc) begin
      rdata = fifo_q.pop_front();
      exp_q.push_back(rdata);
    end
    rempty = (fifo_q.size() == 0);
  endtask

  initial begin
    clear_stats();

    // Reset state
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rinc",    rinc,    0);
    chk("rst_busy",    busy,    0);
    chk("rst_rd_cnt",  rd_cnt,  0);
    chk("rst_m_data",  m_data,  0);

    // Single word 0x5A
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    fifo_q.push_back(8'h5A); rempty = 1'b0;
    repeat (8) step();
    chk("single_reads",   n_acc, 1);
    chk("single_latency", first_vld - first_acc, 2);
    chk("single_words",   n_vld, 1);
    chk("single_rd_cnt",  rd_cnt, 1);
    chk("single_first",   first_vld >= 0, 1);

    // Backpressure: 0x01..0x05 with m_ready low
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    load(0, 0);
    for (int i = 1; i <= 5; i++) fifo_q.push_back(8'(i));
    rempty = 1'b0;
    repeat (8) step();
    chk("bp_reads",   n_acc, 3);
    chk("bp_rinc",    rinc, 0);
    chk("bp_rd_cnt",  rd_cnt, 3);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_head",    m_data, 8'h01);
    m_ready = 1'b1;
    for (int i = 0; i < 20 && n_vld < 5; i++) step();
    chk("bp_words",   n_vld, 5);
    chk("bp_no_gaps", last_vld - first_vld, 4);
    chk("bp_reads_all", n_acc, 5);

    // 20 back-to-back words
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    load(20, 3);
    for (int i = 0; i < 60 && n_vld < 20; i++) step();
    chk("b2b_words",   n_vld, 20);
    chk("b2b_contig",  last_vld - first_vld, 19);
    chk("b2b_latency", first_vld - first_acc, 2);
    chk("b2b_rd_cnt",  rd_cnt, 20);

    // Drop en with 1 in flight and 2 buffered
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    load(10, 11);
    for (int i = 0; i < 20 && n_acc < 3; i++) step();
    chk("drain_pre_reads", n_acc, 3);
    en = 1'b0; m_ready = 1'b1;
    repeat (10) step();
    chk("drain_no_rinc", n_acc, 3);
    chk("drain_words",   n_vld, 3);
    chk("drain_busy",    busy, 0);
    chk("drain_valid",   m_valid, 0);
    chk("drain_fifo",    fifo_q.size(), 7);

    // Asynchronous reset mid-stream with two words buffered
    do_reset();
    en = 1'b1; m_ready = 1'b0;
    load(10, 40);
    for (int i = 0; i < 20 && n_acc < 3; i++) step();
    chk("arst_pre_valid", m_valid, 1);
    chk("arst_pre_cnt",   rd_cnt, 3);
    #3 rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_rinc",    rinc, 0);
    chk("arst_rd_cnt",  rd_cnt, 0);
    chk("arst_busy",    busy, 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    load(17, 90);
    for (int i = 0; i < 50 && n_vld < 17; i++) begin
      step();
      if (last_acc) chk("cnt4_seq", rd_cnt4, n_acc % 16);
    end
    chk("cnt4_final", rd_cnt4, 1);
    chk("cnt16_final", rd_cnt, 17);
    chk("wrap_words", n_vld, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the read-word counter.
REQ-003 SHALL use one clock and an asynchronous active-high reset: clk and rst; polarity and synchronicity are fixed.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  read enable; high permits new FIFO reads.
REQ-007 SHALL have port rempty  input  1  FIFO empty flag, synchronous to clk.
REQ-008 SHALL have port rinc  output  1  FIFO read request.
REQ-009 SHALL have port rdata  input  WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-010 SHALL have port m_valid  output  1  output word valid.
REQ-011 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port m_data  output  WIDTH  output word.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE or any word is in flight or buffered.
REQ-014 SHALL have port rd_cnt  output  CNT_W  count of accepted FIFO reads.

Function
REQ-015 SHALL define an accepted FIFO read as rinc=1 and rempty=0 at a rising edge; read data appears on rdata in the following cycle.
REQ-016 SHALL track one in-flight flag, set on the edge that accepts a read and cleared on the next edge unless another read is accepted.
REQ-017 SHALL hold returned words in a 3-entry in-order buffer; occupancy occ ranges 0..3.
REQ-018 SHALL capture rdata into the buffer tail on every edge where the in-flight flag is 1.
REQ-019 SHALL drive rinc = (state==RUN) & ~rempty & (occ + inflight < 3), with no combinational path from m_ready.
REQ-020 SHALL drive m_valid = (occ != 0) and m_data = buffer head, both from registers.
REQ-021 SHALL pop the head on every edge where m_valid=1 and m_ready=1.
REQ-022 SHALL apply capture and pop together on the same edge, leaving occ unchanged and the order preserved.
REQ-023 SHALL never overflow the buffer and never drop or duplicate a word.
REQ-024 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-025 SHALL reach the first m_valid 2 cycles after the cycle in which rinc is first accepted.
REQ-026 SHALL sustain one word per cycle when m_ready is held high and rempty is held low.
REQ-027 SHALL implement a state machine with states IDLE, RUN and DRAIN.
REQ-028 SHALL move IDLE->RUN on en=1.
REQ-029 SHALL move RUN->DRAIN on en=0.
REQ-030 SHALL move DRAIN->IDLE when inflight=0 and occ=0.
REQ-031 SHALL move DRAIN->RUN when en returns to 1.
REQ-032 SHALL keep rinc=0 in IDLE and DRAIN; buffered words still drain to the output.
REQ-033 SHALL increment rd_cnt by 1 per accepted read, modulo 2^CNT_W, wrapping from all-ones to 0.
REQ-034 SHALL tie busy = (state!=IDLE) | inflight | (occ!=0).

Reset
REQ-035 SHALL, while rst=1 and independent of clk, force state=IDLE, occ=0, inflight=0, rd_cnt=0, m_data=0, m_valid=0, rinc=0 and busy=0.
REQ-036 SHALL discard buffered and in-flight words when rst is asserted mid-operation; the FIFO side is reset by its own owner.
REQ-037 SHALL permit the first rinc no earlier than the first rising edge after rst deasserts with en=1, since IDLE->RUN takes one edge.

Verification
REQ-038 SHALL cover: rst pulse mid-stream with occ=2 -> m_valid=0, rinc=0, rd_cnt=0 immediately, without waiting for a clock edge.
REQ-039 SHALL cover: en=1, rempty low for 1 cycle with rdata=8'h5A, m_ready=1 -> rinc high 1 cycle; m_valid=1 with m_data=8'h5A exactly 2 cycles later; rd_cnt=1.
REQ-040 SHALL cover: m_ready=0 with FIFO holding 0x01..0x05 -> exactly 3 reads then rinc=0, occ=3; m_ready then held 1 -> outputs 0x01..0x05 in order, no gaps after the first.
REQ-041 SHALL cover: 20 back-to-back words with m_ready=1 -> 20 consecutive m_valid cycles after 2-cycle latency; rd_cnt=20.
REQ-042 SHALL cover: en dropped with 1 in flight and 2 buffered, m_ready=1 -> no further rinc; 3 words delivered; then busy=0 and state IDLE.
REQ-043 SHALL cover: CNT_W=4 with 17 reads -> rd_cnt sequence wraps 15 -> 0, ending at 1.
